pkt_rr_arbiter: RTL and testbench
=================================

// Module: pkt_rr_arbiter
// PURPOSE
//  Packet-level round-robin arbiter that shares one network injection port between NUM_IN packetised flit streams.
//  Each stream is the network-side output of a packing converter: HEAD / BODY... / TAIL flits, type in data[`DW-1:`DW-2].
//  Sits between the converters of co-located PEs and the router local input port.
//  Once a HEAD is granted, the source keeps the port until its TAIL handshakes. Packets never interleave.
// PARAMETERS
//  NUM_IN   4     number of requesting streams, 2..16
//  IDX_W    $clog2(NUM_IN)  derived localparam, grant index width
//  (`DW, `HEAD, `BODY, `TAIL, `PKT_LEN come from params.svh)
// PORTS
//  clk          in   1             clock; single clock domain
//  rst          in   1             asynchronous reset, active-high
//  valid_i      in   NUM_IN        per-stream flit valid
//  data_i       in   NUM_IN*`DW    per-stream flit; stream k occupies [k*`DW +: `DW]
//  ready_o      out  NUM_IN        per-stream ready
//  valid_o      out  1             flit valid to network
//  data_o       out  `DW           flit to network
//  ready_i      in   1             network ready
//  grant_o      out  NUM_IN        one-hot current owner; 0 when idle
//  busy_o       out  1             1 while a packet is locked
//  proto_err_o  out  1             sticky: non-HEAD flit offered by a source while the arbiter is idle
// BEHAVIOUR
//  Reset (async, rst=1):
//   - state=IDLE, owner=0, rr_ptr=0, proto_err_o=0.
//   - All outputs low: valid_o, ready_o, grant_o, busy_o, data_o=0.
//  Handshake: a transfer occurs when valid & ready are both high at a rising clk edge.
//   - valid_o does not depend on ready_i.
//  FSM:
//   - IDLE: ready_o=0, valid_o=0.
//     Requesters are streams with valid_i[k] & type==`HEAD.
//     If any exist, the winner is the first requester at or after rr_ptr, searching upward with wrap.
//     Next cycle: owner=winner, state=LOCK.
//     Arbitration costs exactly 1 bubble cycle per packet.
//   - LOCK: pure pass-through of the owner stream, zero latency.
//     valid_o=valid_i[owner], data_o=owner flit, ready_o[owner]=ready_i; all other ready_o=0.
//     On a TAIL transfer: state=IDLE, rr_ptr=(owner+1) mod NUM_IN.
//     No arbitration happens in that same cycle.
//  Non-owners hold their flits stable (valid/data) until granted.
//  Protocol error: in IDLE, if valid_i[k] is high with a non-HEAD type, set proto_err_o (cleared only by rst).
//   - That stream is not granted; its ready stays 0, so it stalls.
//  A HEAD seen in LOCK from the owner is passed through unchanged (no nesting check).
//  Reset mid-packet: abandons the packet at once; downstream sees a truncated packet. Accepted.
//  NUM_IN=1: rr_ptr is stuck at 0; the arbiter still inserts the 1-cycle bubble.
// CONFIGURATION
//  PKT_ARB_OUT_REG_EN defined:
//   - Output passes through a 2-entry skid buffer, so valid_o/data_o are registered.
//   - ready_o[owner] = skid not full; +1 cycle latency; full throughput is preserved.
//   - Release happens on the TAIL entering the skid.
//   - Reset empties the skid.
//  Macro undefined: combinational pass-through as above.
// STRUCTURE
//  pkt_arb_pkg:
//   - flit_type_e {HEAD, BODY, TAIL}, with values tied to the params.svh macros.
//   - arb_state_e {IDLE, LOCK}.
//   - function flit_type(data) returning the top 2 bits.
//  Sub-module rr_arbiter (NUM_IN, combinational):
//   - Inputs req[NUM_IN] and ptr[IDX_W]; outputs gnt_idx and any_gnt.
//  Skid buffer stays inline in this file under the macro.
// TESTING (NUM_IN=4, `PKT_LEN=4, ready_i=1 unless stated)
//  1. Reset: rst pulsed mid-sim -> all outputs 0 the same cycle; after release, first grant goes to the lowest requester.
//  2. Single source: stream 2 sends H,B,B,T -> valid_o high cycles 2-5, data matches, grant_o=4'b0100, then IDLE.
//  3. Fairness: all 4 sources hold back-to-back packets -> grant order 0,1,2,3,0; exactly 1 idle cycle between packets.
//  4. Backpressure: ready_i=0 for 3 cycles mid-BODY -> owner's ready_o low, data_o stable, no flit lost or duplicated.
//  5. No interleave: stream 1 asserts HEAD while stream 0 is locked -> stream 1 ready_o=0 until stream 0's TAIL, then it is granted.
//  6. Error: stream 3 offers BODY while idle -> proto_err_o=1 next cycle and stays high; stream 3 never granted.

Source files
------------

// File: rtl/pkt_arb_pkg.sv
// pkt_arb_pkg: flit encoding and arbiter state types shared by the packet arbiter.
// The flit macros normally come from params.svh. The defaults below keep this slice
// self-contained and yield to any definitions made earlier in the compile.
`ifndef DW
`define DW 32
`endif
`ifndef HEAD
`define HEAD 2'b10
`endif
`ifndef BODY
`define BODY 2'b00
`endif
`ifndef TAIL
`define TAIL 2'b01
`endif
`ifndef PKT_LEN
`define PKT_LEN 4
`endif

package pkt_arb_pkg;

    typedef enum logic [1:0] {
        HEAD = `HEAD,
        BODY = `BODY,
        TAIL = `TAIL
    } flit_type_e;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // The flit type lives in the two most significant bits of every flit.
    function automatic logic [1:0] flit_type(input logic [`DW-1:0] data);
        return data[`DW-1:`DW-2];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotating-priority picker used for packet arbitration.
module rr_arbiter #(
    parameter int NUM_IN = 4,
    parameter int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              any_gnt
);

    // Walk upward from ptr with wrap-around; the first active request found wins.
    always_comb begin
        logic [IDX_W:0]   w_sum;
        logic [IDX_W-1:0] w_cand;
        gnt_idx = '0;
        any_gnt = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (w_sum >= (IDX_W+1)'(NUM_IN)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_IN);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!any_gnt && req[w_cand]) begin
                gnt_idx = w_cand;
                any_gnt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pkt_rr_arbiter.sv
// pkt_rr_arbiter: packet-level round-robin arbiter sharing one network injection port.
// A HEAD wins the port after one arbitration bubble; the owner keeps it until its TAIL is accepted.
// Optional macro PKT_ARB_OUT_REG_EN: registers valid_o/data_o through a 2-entry skid buffer.
module pkt_rr_arbiter
    import pkt_arb_pkg::*;
#(
    parameter int NUM_IN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_IN-1:0]     valid_i,
    input  logic [NUM_IN*`DW-1:0] data_i,
    output logic [NUM_IN-1:0]     ready_o,
    output logic                  valid_o,
    output logic [`DW-1:0]        data_o,
    input  logic                  ready_i,
    output logic [NUM_IN-1:0]     grant_o,
    output logic                  busy_o,
    output logic                  proto_err_o
);

    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    arb_state_e       r_state;
    arb_state_e       w_nextState;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] w_nextOwner;
    logic [IDX_W-1:0] r_rrPtr;
    logic [IDX_W-1:0] w_nextPtr;
    logic             r_protoErr;

    logic [NUM_IN-1:0] w_headReq;
    logic [NUM_IN-1:0] w_badReq;
    logic [IDX_W-1:0]  w_gntIdx;
    logic              w_anyGnt;
    logic [`DW-1:0]    w_ownFlit;
    logic              w_ownValid;
    logic              w_ownReady;
    logic              w_accept;
    logic              w_tailAccept;

    // Sort offered flits: a HEAD is a request, any other type offered while idle is a protocol error.
    always_comb begin
        w_headReq = '0;
        w_badReq  = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (valid_i[k]) begin
                if (flit_type(data_i[k*`DW +: `DW]) == HEAD) begin
                    w_headReq[k] = 1'b1;
                end else begin
                    w_badReq[k] = 1'b1;
                end
            end
        end
    end

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_rrArbiter (
        .req     (w_headReq),
        .ptr     (r_rrPtr),
        .gnt_idx (w_gntIdx),
        .any_gnt (w_anyGnt)
    );

    // Select the owner's stream; its valid only counts while a packet is locked.
    always_comb begin
        w_ownFlit  = '0;
        w_ownValid = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (r_owner == IDX_W'(k)) begin
                w_ownFlit  = data_i[k*`DW +: `DW];
                w_ownValid = (r_state == LOCK) && valid_i[k];
            end
        end
    end

    assign w_accept     = w_ownValid & w_ownReady;
    assign w_tailAccept = w_accept & (flit_type(w_ownFlit) == TAIL);

`ifdef PKT_ARB_OUT_REG_EN
    logic [`DW-1:0] r_skidMem [2];
    logic           r_wrPtr;
    logic           r_rdPtr;
    logic [1:0]     r_count;
    logic           w_pop;

    // Registered output side: the owner may push while a slot is free, the network drains the oldest entry.
    always_comb begin
        w_ownReady = (r_count != 2'd2);
        w_pop      = (r_count != 2'd0) && ready_i;
        valid_o    = (r_count != 2'd0);
        data_o     = r_skidMem[r_rdPtr];
    end

    // Two-entry skid storage; two slots let a flit be accepted every cycle while ready_i toggles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skidMem[0] <= '0;
            r_skidMem[1] <= '0;
            r_wrPtr      <= 1'b0;
            r_rdPtr      <= 1'b0;
            r_count      <= 2'd0;
        end else begin
            if (w_accept) begin
                r_skidMem[r_wrPtr] <= w_ownFlit;
                r_wrPtr            <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end
`else
    // Zero-latency pass-through of the locked owner; the network's ready goes straight back.
    always_comb begin
        w_ownReady = ready_i;
        valid_o    = w_ownValid;
        data_o     = (r_state == LOCK) ? w_ownFlit : '0;
    end
`endif

    // Only the owner sees ready; grant is the one-hot owner while locked and zero when idle.
    always_comb begin
        ready_o = '0;
        grant_o = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if ((r_state == LOCK) && (r_owner == IDX_W'(k))) begin
                ready_o[k] = w_ownReady;
                grant_o[k] = 1'b1;
            end
        end
    end

    assign busy_o      = (r_state == LOCK);
    assign proto_err_o = r_protoErr;

    // Next-state logic: arbitrate only in IDLE, release and advance the pointer on the owner's TAIL.
    always_comb begin
        w_nextState = r_state;
        w_nextOwner = r_owner;
        w_nextPtr   = r_rrPtr;
        case (r_state)
            IDLE: begin
                if (w_anyGnt) begin
                    w_nextState = LOCK;
                    w_nextOwner = w_gntIdx;
                end
            end
            LOCK: begin
                if (w_tailAccept) begin
                    w_nextState = IDLE;
                    w_nextPtr   = (r_owner == IDX_W'(NUM_IN-1)) ? '0 : r_owner + 1'b1;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State, owner, pointer and the sticky protocol-error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_rrPtr    <= '0;
            r_protoErr <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_owner <= w_nextOwner;
            r_rrPtr <= w_nextPtr;
            if ((r_state == IDLE) && (|w_badReq)) begin
                r_protoErr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// tb_pkt_rr_arbiter: scoreboard bench for pkt_rr_arbiter with NUM_IN=4.
// Each applyStimulus call queues one packet at a source and pushes its flits onto the
// scoreboard; calls are made in the grant order worked out by hand for each scenario.
`ifndef DW
`define DW 32
`endif
`ifndef HEAD
`define HEAD 2'b10
`endif
`ifndef BODY
`define BODY 2'b00
`endif
`ifndef TAIL
`define TAIL 2'b01
`endif
`ifndef PKT_LEN
`define PKT_LEN 4
`endif

module tb_pkt_rr_arbiter;

    localparam int NUM_IN = 4;
    localparam int DW     = `DW;
    localparam logic [1:0] T_HEAD = `HEAD;
    localparam logic [1:0] T_BODY = `BODY;
    localparam logic [1:0] T_TAIL = `TAIL;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_IN-1:0]     valid_i;
    logic [NUM_IN*DW-1:0]  data_i;
    logic [NUM_IN-1:0]     ready_o;
    logic                  valid_o;
    logic [DW-1:0]         data_o;
    logic                  ready_i;
    logic [NUM_IN-1:0]     grant_o;
    logic                  busy_o;
    logic                  proto_err_o;

    typedef struct {
        logic [DW-1:0]     data;
        logic [NUM_IN-1:0] grant;
    } expEntry_t;

    expEntry_t     expQ [$];
    logic [DW-1:0] srcQ [NUM_IN][$];
    int            checkCount  = 0;
    int            passCount   = 0;
    int            cycle       = 0;
    int            validCnt    = 0;
    int            lastTailCyc = -1;
    bit            gapCheck    = 1'b0;

    pkt_rr_arbiter #(.NUM_IN(NUM_IN)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .data_i      (data_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .ready_i     (ready_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .proto_err_o (proto_err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    function automatic logic [DW-1:0] mkFlit(input logic [1:0] t, input int s, input int p, input int b);
        logic [DW-1:0] f;
        f = '0;
        f[DW-1:DW-2] = t;
        f[23:16]     = 8'(s);
        f[15:8]      = 8'(p);
        f[7:0]       = 8'(b);
        return f;
    endfunction

    function automatic int pendingFlits();
        int n = 0;
        for (int k = 0; k < NUM_IN; k++) n += srcQ[k].size();
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input int s, input int p);
        expEntry_t   e;
        logic [1:0]  t;
        for (int b = 0; b < `PKT_LEN; b++) begin
            t = (b == 0) ? T_HEAD : ((b == `PKT_LEN-1) ? T_TAIL : T_BODY);
            srcQ[s].push_back(mkFlit(t, s, p, b));
            e.data  = mkFlit(t, s, p, b);
            e.grant = NUM_IN'(1) << s;
            expQ.push_back(e);
        end
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while ((expQ.size() != 0 || pendingFlits() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #2;
        checkOutput({name, " drained"}, 64'(expQ.size() + pendingFlits()), 64'd0);
    endtask

    task automatic checkAllIdle(input string name);
        checkOutput({name, " valid_o"},     64'(valid_o),     64'd0);
        checkOutput({name, " ready_o"},     64'(ready_o),     64'd0);
        checkOutput({name, " grant_o"},     64'(grant_o),     64'd0);
        checkOutput({name, " busy_o"},      64'(busy_o),      64'd0);
        checkOutput({name, " data_o"},      64'(data_o),      64'd0);
        checkOutput({name, " proto_err_o"}, 64'(proto_err_o), 64'd0);
    endtask

    // Source models: present the head of each queue, retire it after a handshake seen before the edge.
    initial begin : driver
        logic [NUM_IN-1:0] xfer;
        valid_i = '0;
        data_i  = '0;
        forever begin
            @(negedge clk);
            xfer = valid_i & ready_o;
            @(posedge clk);
            #1;
            for (int k = 0; k < NUM_IN; k++) begin
                if (xfer[k] && !rst && srcQ[k].size() > 0) void'(srcQ[k].pop_front());
                if (srcQ[k].size() > 0) begin
                    valid_i[k]            = 1'b1;
                    data_i[k*DW +: DW]    = srcQ[k][0];
                end else begin
                    valid_i[k] = 1'b0;
                end
            end
        end
    end

    // Monitor: every flit the network accepts must be the next scoreboard entry.
    always @(negedge clk) begin
        expEntry_t e;
        if (valid_o) validCnt++;
        if (!rst && valid_o && ready_i) begin
            if (expQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL extra_flit: got 0x%0h, required no transfer", data_o);
            end else begin
                e = expQ.pop_front();
                checkOutput("flit data", 64'(data_o), 64'(e.data));
                checkOutput("flit grant", 64'(grant_o), 64'(e.grant));
                if (gapCheck && e.data[DW-1:DW-2] == T_HEAD && lastTailCyc >= 0)
                    checkOutput("bubble gap", 64'(cycle + 1 - lastTailCyc), 64'd2);
                if (e.data[DW-1:DW-2] == T_TAIL) lastTailCyc = cycle + 1;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int n;
        rst     = 1'b1;
        ready_i = 1'b1;
        #3;
        checkAllIdle("reset");
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        // Fairness: all four streams request together from rr_ptr=0 -> 0,1,2,3 then stream 0 again.
        gapCheck    = 1'b1;
        lastTailCyc = -1;
        @(posedge clk); #2;
        applyStimulus(0, 0);
        applyStimulus(1, 1);
        applyStimulus(2, 2);
        applyStimulus(3, 3);
        applyStimulus(0, 4);
        waitDrain("fairness");
        gapCheck = 1'b0;

        // Single source: stream 2 alone, four valid cycles with grant 4'b0100, then idle.
        validCnt = 0;
        applyStimulus(2, 5);
        waitDrain("single");
        repeat (3) @(posedge clk);
        #2;
        checkOutput("single valid cycles", 64'(validCnt), 64'd4);
        checkOutput("single idle grant", 64'(grant_o), 64'd0);
        checkOutput("single idle busy", 64'(busy_o), 64'd0);

        // Backpressure: stall the network for three cycles while stream 1 offers its first BODY.
        applyStimulus(1, 6);
        n = 0;
        while (expQ.size() != 3 && n < 50) begin @(posedge clk); #2; n++; end
        checkOutput("bp head accepted", 64'(expQ.size()), 64'd3);
        ready_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("bp owner ready", 64'(ready_o[1]), 64'd0);
            checkOutput("bp valid held", 64'(valid_o), 64'd1);
            checkOutput("bp data held", 64'(data_o), 64'(mkFlit(T_BODY, 1, 6, 1)));
        end
        @(posedge clk); #2;
        ready_i = 1'b1;
        waitDrain("backpressure");

        // No interleave: stream 1 raises a HEAD while stream 0 holds the port.
        applyStimulus(0, 7);
        n = 0;
        while (grant_o != 4'b0001 && n < 50) begin @(posedge clk); #2; n++; end
        checkOutput("nest owner granted", 64'(grant_o), 64'h1);
        applyStimulus(1, 8);
        repeat (2) @(negedge clk);
        checkOutput("nest s1 blocked", 64'(ready_o[1]), 64'd0);
        checkOutput("nest owner kept", 64'(grant_o), 64'h1);
        waitDrain("no interleave");

        // Protocol error: stream 3 offers a BODY while idle.
        @(posedge clk); #2;
        srcQ[3].push_back(mkFlit(T_BODY, 3, 9, 1));
        @(posedge clk); #2;
        checkOutput("err clear before", 64'(proto_err_o), 64'd0);
        @(posedge clk); #2;
        checkOutput("err set", 64'(proto_err_o), 64'd1);
        repeat (4) begin
            @(posedge clk); #2;
            checkOutput("err sticky", 64'(proto_err_o), 64'd1);
            checkOutput("err s3 not granted", 64'(grant_o), 64'd0);
            checkOutput("err s3 stalled", 64'(ready_o[3]), 64'd0);
        end
        srcQ[3].delete();
        repeat (2) @(posedge clk);
        #2;
        checkOutput("err sticky after", 64'(proto_err_o), 64'd1);

        // Reset mid-packet: stream 0 is abandoned; afterwards streams 1 and 3 compete, 1 wins from pointer 0.
        applyStimulus(0, 10);
        n = 0;
        while (expQ.size() != 3 && n < 50) begin @(posedge clk); #2; n++; end
        checkOutput("rst head accepted", 64'(expQ.size()), 64'd3);
        rst = 1'b1;
        srcQ[0].delete();
        expQ.delete();
        #1;
        checkAllIdle("mid reset");
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #2;
        applyStimulus(1, 11);
        applyStimulus(3, 12);
        waitDrain("post reset");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
